// File: rtl/pe_result_arbiter.sv
// pe_result_arbiter: round-robin collector that serialises PE results through a small output FIFO, one frame per start.
// Optional feature macro RESULT_TAG_EN adds outTag, the granted PE index stored alongside each FIFO entry.
module pe_result_arbiter #(
    parameter int NUM_PE     = 5,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       start,
    input  logic [7:0]                 frameLen,
    input  logic [NUM_PE-1:0]          peValid,
    input  logic [NUM_PE*DATA_W-1:0]   peData,
    output logic [NUM_PE-1:0]          peAck,
    output logic [DATA_W-1:0]          outData,
    output logic                       outValid,
`ifdef RESULT_TAG_EN
    output logic [$clog2(NUM_PE)-1:0]  outTag,
`endif
    input  logic                       outReady,
    output logic                       busy,
    output logic                       done
);

    localparam int PTR_W  = $clog2(NUM_PE);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int SUM_W  = PTR_W + 1;

    localparam logic [PTR_W-1:0] RR_RESET = PTR_W'(NUM_PE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [SUM_W-1:0] SUM_NPE  = SUM_W'(NUM_PE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [7:0]          remaining_q, remaining_d;
    logic [PTR_W-1:0]    rr_q,        rr_d;
    logic [ADDR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]    count_q,     count_d;
    logic                done_q,      done_d;

    logic [DATA_W-1:0]   data_mem [FIFO_DEPTH];
`ifdef RESULT_TAG_EN
    logic [PTR_W-1:0]    tag_mem  [FIFO_DEPTH];
`endif

    logic                fifo_full;
    logic                fifo_empty;
    logic                found;
    logic                grant;
    logic                push;
    logic                pop;
    logic [PTR_W-1:0]    winner;
    logic [SUM_W-1:0]    probe;
    logic [DATA_W-1:0]   win_data;

    // Round-robin search starts one past the last winner and wraps modulo NUM_PE.
    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        found  = 1'b0;
        winner = rr_q;
        probe  = '0;
        for (int k = 1; k <= NUM_PE; k++) begin
            probe = {1'b0, rr_q} + SUM_W'(k);
            if (probe >= SUM_NPE) begin
                probe = probe - SUM_NPE;
            end
            if (!found && peValid[probe[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = probe[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (winner == PTR_W'(i)) begin
                win_data = peData[i*DATA_W +: DATA_W];
            end
        end
    end

    // Fullness is judged on the count before this cycle's pop, so a full FIFO never takes a push.
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign grant      = (state_q == COLLECT) && !fifo_full && (remaining_q != 8'd0) && found;
    assign push       = grant;
    assign pop        = !fifo_empty && outReady;

    always_comb begin
        peAck = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            peAck[i] = grant && (winner == PTR_W'(i));
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rr_d        = rr_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = frameLen;
                    state_d     = (frameLen != 8'd0) ? COLLECT : FLUSH;
                end
            end
            COLLECT: begin
                if (grant) begin
                    remaining_d = remaining_q - 8'd1;
                    rr_d        = winner;
                    if (remaining_q == 8'd1) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // No pushes here, so count_d reflects the FIFO after this cycle's pop.
                if (count_d == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            remaining_q <= 8'd0;
            rr_q        <= RR_RESET;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rr_q        <= rr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

    // NOTE: the storage array has no reset; an empty count makes stale entries unobservable.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= win_data;
`ifdef RESULT_TAG_EN
            tag_mem[wr_ptr_q]  <= winner;
`endif
        end
    end

    assign outValid = !fifo_empty;
    assign outData  = fifo_empty ? '0 : data_mem[rd_ptr_q];
`ifdef RESULT_TAG_EN
    assign outTag   = fifo_empty ? '0 : tag_mem[rd_ptr_q];
`endif
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule
